mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: STARVE_MAX, default 3, maximum consecutive data grants while fetch waits (range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 if_req  input  1  instruction fetch request; held until if_ack.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched instruction; valid while if_ack=1.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 mem_req  input  1  data access request; held until mem_ack.
REQ-010 mem_we  input  1  1 = write, 0 = read.
REQ-011 mem_addr  input  32  data byte address.
REQ-012 mem_wdata  input  32  store data.
REQ-013 mem_rdata  output  32  load data; valid while mem_ack=1.
REQ-014 mem_ack  output  1  one-cycle data completion pulse.
REQ-015 ram_req  output  1  request to the shared single-port memory.
REQ-016 ram_we  output  1  memory write enable.
REQ-017 ram_addr  output  32  memory address.
REQ-018 ram_wdata  output  32  memory write data.
REQ-019 ram_rdata  input  32  memory read data; valid when ram_ready=1.
REQ-020 ram_ready  input  1  memory completion; sampled only while ram_req=1.
REQ-021 stall_if  output  1  if_req & ~if_ack, combinational.
REQ-022 stall_mem  output  1  mem_req & ~mem_ack, combinational.

Function
REQ-023 The FSM SHALL have states IDLE, IF_BUSY, MEM_BUSY and RESP.
REQ-024 In IDLE, when mem_req=1, it SHALL go to MEM_BUSY, unless if_req=1 and starve_cnt==STARVE_MAX; in that case it SHALL go to IF_BUSY.
REQ-025 In IDLE, when only if_req=1, it SHALL go to IF_BUSY; with no request it SHALL stay in IDLE.
REQ-026 On the grant edge it SHALL register ram_req=1 and the ram_addr/ram_we/ram_wdata of the winner; ram_we=0 for fetch.
REQ-027 ram_* outputs SHALL hold stable in *_BUSY until ram_ready=1.
REQ-028 On ram_ready=1 in *_BUSY: ram_req SHALL deassert, the rdata of the winner SHALL capture ram_rdata (write: unchanged), and the FSM SHALL enter RESP.
REQ-029 In RESP, exactly one of if_ack/mem_ack (matching the granted port) SHALL be 1 for one cycle; next state SHALL be IDLE, and requests SHALL NOT be sampled in RESP.
REQ-030 Minimum latency SHALL be: request at IDLE cycle N, ram_req at N+1, ram_ready at N+1 gives ack at N+2; peak throughput SHALL be one transfer per 3 cycles.
REQ-031 A request dropped mid-transfer SHALL NOT abort it; the transfer completes and ack still pulses.
REQ-032 starve_cnt (4 bits) SHALL increment on a MEM grant while if_req=1, saturate at STARVE_MAX, and clear on any IF grant.
REQ-033 if_rdata/mem_rdata SHALL retain their last captured value outside ack cycles.
REQ-034 When ram_ready never asserts, the FSM SHALL stay in *_BUSY indefinitely and raise no error.

Reset
REQ-035 reset=1 SHALL asynchronously force IDLE, starve_cnt=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0.
REQ-036 Reset mid-transfer SHALL drop ram_req immediately and discard the transfer with no ack.

Configuration
REQ-037 With MEM_ARB_FAIRNESS_EN defined, starve_cnt and the REQ-024 override SHALL be implemented.
REQ-038 Without MEM_ARB_FAIRNESS_EN, starve_cnt SHALL be absent and mem_req SHALL always win over if_req.

Verification
REQ-039 Single fetch: if_req=1 with if_addr=0x00400000, ram_ready=1 at first ram_req cycle, ram_rdata=0x20080005 -> ram_addr=0x00400000, ram_we=0, if_ack=1 at N+2 with if_rdata=0x20080005.
REQ-040 Store: mem_req=1, mem_we=1, addr=0x10, wdata=0xDEADBEEF, ram_ready delayed 3 cycles -> ram_* stable for 4 cycles, mem_ack at N+5, mem_rdata unchanged.
REQ-041 Simultaneous if_req and mem_req, STARVE_MAX=3, fairness on, mem_req held -> grant order MEM, MEM, MEM, IF; with fairness off -> IF never granted while mem_req=1.
REQ-042 Back-to-back: if_req held, ram_ready always 1 -> if_ack pulses every 3 cycles, never in consecutive cycles.
REQ-043 Reset asserted in MEM_BUSY -> ram_req=0 the same cycle, no mem_ack, IDLE after release.
REQ-044 stall check: mem_req=1 with 2-cycle ram latency -> stall_mem=1 every cycle until and excluding the mem_ack cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-port memory.
// Define MEM_ARB_FAIRNESS_EN to let a waiting fetch win after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} state_t;

  state_t state;
  logic   pickIf;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarveMax
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] starveCnt;
  // Data port wins unless fetch has already been passed over STARVE_MAX times.
  always_comb pickIf = if_req & (~mem_req | (starveCnt == 4'(STARVE_MAX)));
`else
  always_comb pickIf = if_req & ~mem_req;
`endif

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
      starveCnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pickIf) begin
            state     <= IF_BUSY;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
            starveCnt <= '0;
`endif
          end else if (mem_req) begin
            state     <= MEM_BUSY;
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
`ifdef MEM_ARB_FAIRNESS_EN
            if (if_req && starveCnt != 4'(STARVE_MAX))
              starveCnt <= starveCnt + 4'd1;
`endif
          end
        end
        IF_BUSY, MEM_BUSY: begin
          // Transfer runs to completion even if the requester lets go.
          if (ram_ready) begin
            state   <= RESP;
            ram_req <= 1'b0;
            if (state == IF_BUSY) begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              mem_ack <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end
          end
        end
        RESP: begin
          state   <= IDLE;
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we, ram_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ack, mem_ack, ram_req, ram_we, stall_if, stall_mem;
  int total = 0;
  int bad = 0;

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick();
    total++;
    if ({ram_req, ram_we, if_ack, mem_ack} !== 4'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_ctrl: got req=%b we=%b ifack=%b memack=%b addr=%h wdata=%h, want all 0",
                      ram_req, ram_we, if_ack, mem_ack, ram_addr, ram_wdata);
    end
    total++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got if=%h mem=%h, want 0", if_rdata, mem_rdata);
    end
    reset = 1'b0;
    tick();
    total++;
    if (ram_req !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got req=%b stall_if=%b stall_mem=%b, want 0", ram_req, stall_if, stall_mem);
    end
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    #1 total++;
    if (stall_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_N: got %b want 1", stall_if); end
    tick();
    total++;
    if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h0040_0000) begin
      bad++; $display("FAIL fetch_grant: got req=%b we=%b addr=%h want 1 0 00400000", ram_req, ram_we, ram_addr);
    end
    ram_ready = 1'b1; ram_rdata = 32'h2008_0005;
    tick();
    total++;
    if (if_ack !== 1'b1 || mem_ack !== 1'b0 || if_rdata !== 32'h2008_0005 || ram_req !== 1'b0) begin
      bad++; $display("FAIL fetch_ack: got ifack=%b memack=%b rdata=%h req=%b want 1 0 20080005 0",
                      if_ack, mem_ack, if_rdata, ram_req);
    end
    total++;
    if (stall_if !== 1'b0) begin bad++; $display("FAIL fetch_stall_ack: got %b want 0", stall_if); end
    if_req = 1'b0; ram_ready = 1'b0; ram_rdata = 32'h1111_1111;
    tick();
    total++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h2008_0005) begin
      bad++; $display("FAIL fetch_retain: got ack=%b rdata=%h want 0 20080005", if_ack, if_rdata);
    end
  endtask

  task automatic test_store;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    ram_rdata = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin mem_addr = 32'h99; mem_wdata = 32'h0; end
      total++;
      if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h10 || ram_wdata !== 32'hDEAD_BEEF || mem_ack !== 1'b0) begin
        bad++; $display("FAIL store_hold c%0d: got req=%b we=%b addr=%h wdata=%h ack=%b want 1 1 10 deadbeef 0",
                        c, ram_req, ram_we, ram_addr, ram_wdata, mem_ack);
      end
      if (c == 4) ram_ready = 1'b1;
    end
    tick();
    total++;
    if (mem_ack !== 1'b1 || if_ack !== 1'b0 || mem_rdata !== 32'h0) begin
      bad++; $display("FAIL store_ack: got memack=%b ifack=%b rdata=%h want 1 0 0", mem_ack, if_ack, mem_rdata);
    end
    mem_req = 1'b0; mem_we = 1'b0; ram_ready = 1'b0;
    tick();
  endtask

  task automatic test_load_stall;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) tick();
      #1;
      total++;
      if (stall_mem !== (c != 3)) begin
        bad++; $display("FAIL load_stall c%0d: got %b want %b", c, stall_mem, c != 3);
      end
      if (c == 2) begin ram_ready = 1'b1; ram_rdata = 32'hCAFE_F00D; end
    end
    total++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL load_ack: got ack=%b rdata=%h want 1 cafef00d", mem_ack, mem_rdata);
    end
    mem_req = 1'b0; ram_ready = 1'b0; ram_rdata = 32'h0;
    tick();
    total++;
    if (mem_ack !== 1'b0 || mem_rdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL load_retain: got ack=%b rdata=%h want 0 cafef00d", mem_ack, mem_rdata);
    end
  endtask

  task automatic test_drop;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80;
    tick();
    mem_req = 1'b0;
    tick();
    total++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h80) begin
      bad++; $display("FAIL drop_hold: got req=%b addr=%h want 1 80", ram_req, ram_addr);
    end
    ram_ready = 1'b1; ram_rdata = 32'h0BAD_F00D;
    tick();
    total++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL drop_ack: got ack=%b rdata=%h want 1 0badf00d", mem_ack, mem_rdata);
    end
    ram_ready = 1'b0;
    tick();
  endtask

  task automatic test_priority;
    logic expIf, gotIf;
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      expIf = (i == 3);
`else
      expIf = 1'b0;
`endif
      gotIf = (ram_addr == 32'h1000);
      total++;
      if (ram_req !== 1'b1 || gotIf !== expIf) begin
        bad++; $display("FAIL prio_grant%0d: got req=%b addr=%h want req=1 if_win=%b", i, ram_req, ram_addr, expIf);
      end
      ram_ready = 1'b1; ram_rdata = 32'h100 + i;
      tick();
      total++;
      if (if_ack !== expIf || mem_ack !== ~expIf) begin
        bad++; $display("FAIL prio_ack%0d: got ifack=%b memack=%b want %b %b", i, if_ack, mem_ack, expIf, ~expIf);
      end
      ram_ready = 1'b0;
      if (i == 3) begin if_req = 1'b0; mem_req = 1'b0; end
      tick();
      tick();
    end
  endtask

  task automatic test_back_to_back;
    if_req = 1'b1; if_addr = 32'h3000; ram_ready = 1'b1; ram_rdata = 32'hA5A5_0001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      total++;
      if (if_ack !== (c % 3 == 2)) begin
        bad++; $display("FAIL b2b_ack c%0d: got %b want %b", c, if_ack, c % 3 == 2);
      end
      if (c == 11) if_req = 1'b0;
    end
    ram_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h44; mem_wdata = 32'h55;
    tick();
    total++;
    if (ram_req !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got req=%b want 1", ram_req); end
    #1 reset = 1'b1;
    #1 total++;
    if (ram_req !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mid_async: got req=%b we=%b addr=%h want 0 0 0", ram_req, ram_we, ram_addr);
    end
    mem_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (mem_ack !== 1'b0 || ram_req !== 1'b0) begin
        bad++; $display("FAIL rst_mid_noack c%0d: got ack=%b req=%b want 0 0", c, mem_ack, ram_req);
      end
    end
    if_req = 1'b1; if_addr = 32'h4000;
    tick();
    total++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h4000) begin
      bad++; $display("FAIL rst_mid_idle: got req=%b addr=%h want 1 4000", ram_req, ram_addr);
    end
    ram_ready = 1'b1;
    tick();
    if_req = 1'b0; ram_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_ready = 1'b0; ram_rdata = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_load_stall();
    test_drop();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
